// File: rtl/load_store_unit_if.sv
// Core-request, completion and data-memory signals of the load/store unit.
// slave is the unit's own view; master is the view of the core and memory around it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/halfword/word accesses to a word-wide memory,
// with read-modify-write for sub-word stores and alignment/encoding checks.
module load_store_unit (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q, data_d;

    logic        accept;
    logic        acc_err;
    logic        acc_sw;
    logic        in_rd, in_wr;

    function automatic logic access_error(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        logic legal;
        logic misaligned;
        if (we)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misaligned;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic        [31:0] r;
        b  = word[{off, 3'b000} +: 8];
        h  = word[{off[1], 4'b0000} +: 16];
        sb = signed'(b);
        sh = signed'(h);
        case (f3)
            3'b000:  r = 32'(sb);
            3'b001:  r = 32'(sh);
            3'b010:  r = word;
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] m;
        m = word;
        if (f3[1:0] == 2'b01)
            m[{off[1], 4'b0000} +: 16] = wdata[15:0];
        else
            m[{off, 3'b000} +: 8] = wdata[7:0];
        return m;
    endfunction

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign acc_err = access_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign acc_sw  = bus.req_we && (bus.req_funct3 == 3'b010);
    assign in_rd   = (state_q == RD);
    assign in_wr   = (state_q == WR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err)     state_d = RESP;
                    else if (acc_sw) state_d = WR;
                    else             state_d = RD;
                end
            end
            RD:      state_d = WAIT;
            WAIT:    state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset returns to IDLE at once; every output below is decoded from the
    // state, so the whole port snaps to its idle values without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                err_q    <= acc_err;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        if (we_q)
            data_d = store_merge(funct3_q, addr_q[1:0], bus.mem_rdata, wdata_q);
        else
            data_d = load_extract(funct3_q, addr_q[1:0], bus.mem_rdata);
    end

    // Datapath registers carry no reset: they are only observed in states
    // that are reached after being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
        if (state_q == WAIT)
            data_q <= data_d;
    end

    always_comb begin
        bus.req_ready    = (state_q == IDLE);
        bus.mem_r_enable = in_rd;
        bus.mem_w_enable = in_wr;
        bus.mem_addr     = 32'h0;
        bus.mem_wdata    = 32'h0;
        if (in_rd || in_wr)
            bus.mem_addr = {addr_q[31:2], 2'b00};
        if (in_wr)
            bus.mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : data_q;
        bus.resp_valid = (state_q == RESP);
        bus.resp_error = (state_q == RESP) && err_q;
        bus.resp_rdata = 32'h0;
        if ((state_q == RESP) && !err_q && !we_q)
            bus.resp_rdata = data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a response scoreboard, plus
// back-to-back and reset-during-RMW sequences against a word-wide memory model.
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] chk_addr;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    localparam int NV = 18;
    vec_t  vecs [NV];
    exp_t  sbq [$];

    int checks = 0;
    int errors = 0;
    int pushes = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide memory: one-cycle read latency, plus a preload port for the bench.
    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr[11:2]] <= pre_data;
        else if (bus.mem_w_enable) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_r_enable) begin
            bus.mem_rdata <= mem[bus.mem_addr[11:2]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    int viol = 0;
    int resp_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_r_enable && bus.mem_w_enable)
            viol <= viol + 1;
        else if (!bus.mem_r_enable && !bus.mem_w_enable &&
                 ((bus.mem_addr != 32'h0) || (bus.mem_wdata != 32'h0)))
            viol <= viol + 1;
        if (bus.resp_valid)
            resp_cnt <= resp_cnt + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic svc();
        exp_t e;
        if (bus.resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid at cycle %0d, expected none", cyc);
            end else begin
                e = sbq.pop_front();
                check32("resp_rdata", bus.resp_rdata, e.rdata);
                check32("resp_error", {31'h0, bus.resp_error}, {31'h0, e.err});
                check32("latency", cyc - e.acc + 1, e.lat);
            end
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        svc();
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 10) begin
            nedge();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending responses, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_req(input vec_t v);
        int n = 0;
        nedge();
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && n < 10) begin
            nedge();
            n++;
        end
        check32("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        sbq.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat, acc: cyc});
        pushes++;
        nedge();
        bus.req_valid = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req_ready"},  {31'h0, bus.req_ready},    32'h1);
        check32({tag, "_resp_valid"}, {31'h0, bus.resp_valid},   32'h0);
        check32({tag, "_resp_error"}, {31'h0, bus.resp_error},   32'h0);
        check32({tag, "_resp_rdata"}, bus.resp_rdata,            32'h0);
        check32({tag, "_mem_r_en"},   {31'h0, bus.mem_r_enable}, 32'h0);
        check32({tag, "_mem_w_en"},   {31'h0, bus.mem_w_enable}, 32'h0);
        check32({tag, "_mem_addr"},   bus.mem_addr,              32'h0);
        check32({tag, "_mem_wdata"},  bus.mem_wdata,             32'h0);
    endtask

    initial begin
        int rd0, wr0;
        logic ready_pat [5];

        //          we    f3      addr      wdata          exp_rdata      err  lat rd wr chk_addr   exp_word
        vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,         32'hFFFF_FF81, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,         32'h0000_0081, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,         32'hFFFF_8180, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,         32'h0000_7F01, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[4]  = '{1'b0, 3'b000, 32'h101, 32'h0,         32'h0000_007F, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[5]  = '{1'b0, 3'b000, 32'h102, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[6]  = '{1'b0, 3'b010, 32'h100, 32'h0,         32'h8180_7F01, 1'b0, 3, 1, 0, 32'h100, 32'h8180_7F01};
        vecs[7]  = '{1'b1, 3'b000, 32'h201, 32'hFFFF_FFAB, 32'h0,         1'b0, 4, 1, 1, 32'h200, 32'h1122_AB44};
        vecs[8]  = '{1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1, 32'h300, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 3'b001, 32'h502, 32'h1234_5678, 32'h0,         1'b0, 4, 1, 1, 32'h500, 32'h5678_F00D};
        vecs[10] = '{1'b0, 3'b101, 32'h502, 32'h0,         32'h0000_5678, 1'b0, 3, 1, 0, 32'h500, 32'h5678_F00D};
        vecs[11] = '{1'b1, 3'b000, 32'h203, 32'h0000_005A, 32'h0,         1'b0, 4, 1, 1, 32'h200, 32'h5A22_AB44};
        vecs[12] = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h100, 32'h8180_7F01};
        vecs[13] = '{1'b0, 3'b001, 32'h101, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h100, 32'h8180_7F01};
        vecs[14] = '{1'b0, 3'b011, 32'h100, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h100, 32'h8180_7F01};
        vecs[15] = '{1'b1, 3'b010, 32'h301, 32'h0BAD_F00D, 32'h0,         1'b1, 1, 0, 0, 32'h300, 32'hDEAD_BEEF};
        vecs[16] = '{1'b1, 3'b100, 32'h300, 32'h0BAD_F00D, 32'h0,         1'b1, 1, 0, 0, 32'h300, 32'hDEAD_BEEF};
        vecs[17] = '{1'b1, 3'b001, 32'h201, 32'h0000_FFFF, 32'h0,         1'b1, 1, 0, 0, 32'h200, 32'h5A22_AB44};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        pre_we         = 1'b0;
        pre_addr       = 32'h0;
        pre_data       = 32'h0;
        rst_n          = 1'b0;

        #2;
        check_reset_outputs("por");

        preload(32'h100, 32'h8180_7F01);
        preload(32'h200, 32'h1122_3344);
        preload(32'h300, 32'h0000_0000);
        preload(32'h400, 32'h5566_7788);
        preload(32'h500, 32'hCAFE_F00D);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            do_req(vecs[i]);
            check32($sformatf("v%0d_reads", i),  rd_cnt - rd0, vecs[i].exp_rd);
            check32($sformatf("v%0d_writes", i), wr_cnt - wr0, vecs[i].exp_wr);
            check32($sformatf("v%0d_memword", i), mem[vecs[i].chk_addr[11:2]], vecs[i].exp_word);
        end

        // Back-to-back LW with req_valid held: next accept right after RESP.
        ready_pat[0] = 1'b1;
        ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0;
        ready_pat[3] = 1'b0;
        ready_pat[4] = 1'b1;
        rd0 = rd_cnt;
        nedge();
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        bus.req_wdata  = 32'h0;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check32($sformatf("b2b_ready%0d", i), {31'h0, bus.req_ready}, {31'h0, ready_pat[i]});
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                sbq.push_back('{rdata: 32'h8180_7F01, err: 1'b0, lat: 3, acc: cyc});
                pushes++;
            end
            nedge();
        end
        bus.req_valid = 1'b0;
        drain();
        check32("b2b_reads", rd_cnt - rd0, 2);

        // SH interrupted by reset while waiting on the read data.
        wr0 = wr_cnt;
        nedge();
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h402;
        bus.req_wdata  = 32'h0000_9999;
        bus.req_valid  = 1'b1;
        check32("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        nedge();
        bus.req_valid = 1'b0;
        check32("rst_in_rd", {31'h0, bus.mem_r_enable}, 32'h1);
        nedge();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) nedge();
        rst_n = 1'b1;
        repeat (6) nedge();
        check32("rst_mem_0x400", mem[10'h100], 32'h5566_7788);
        check32("rst_writes", wr_cnt - wr0, 0);

        // A clean access still works after the abandoned one.
        do_req('{1'b0, 3'b010, 32'h400, 32'h0, 32'h5566_7788, 1'b0, 3, 1, 0, 32'h400, 32'h5566_7788});
        repeat (3) nedge();

        check32("bus_rules", viol, 0);
        check32("resp_count", resp_cnt, pushes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
